checkpoint_monitor: RTL and testbench
=====================================

Name: checkpoint_monitor

Overview:
- Synthesizable, parametrised successor to the bench-side checkbits watcher.
- Watches the mprj_io[31:16] checkpoint bus driven by firmware and decodes start/end markers for a fixed sequence of hardware tests (FIR, matmul, qsort, ...). The sequence repeats a configurable number of times.
- Measures per-test latency, enforces timeouts and flags ordering errors.
- Sits in the user project beside the accelerators. Its status outputs can be mapped to LA/Wishbone readback, which removes the need for testbench-only monitoring.

Parameters:
- CHECK_W, 16, width of the checkbits bus.
- MAGIC, 8'hAB, marker prefix. Must equal checkbits[CHECK_W-1:CHECK_W-8].
- NUM_TESTS, 3, number of tests per pass. Test IDs run 0..NUM_TESTS-1, max 16.
- RERUNS, 3, number of full passes expected.
- CNT_W, 24, width of the latency and timeout counters.
- TIMEOUT, 250000, maximum cycles allowed waiting for any expected marker.
- STABLE_CYC, 4, consecutive identical synced samples required before a value is accepted.

Ports:
- clock  in  1  system clock.
- resetb  in  1  synchronous active-low reset.
- checkbits  in  CHECK_W  raw checkpoint bus. Asynchronous to clock.
- arm  in  1  single-cycle start pulse. Honoured only in IDLE.
- rd_idx  in  4  test index for the max-latency readout.
- busy  out  1  high in WAIT_START or WAIT_END.
- done  out  1  sticky; all passes completed.
- fail  out  1  sticky; error detected.
- fail_code  out  2  0 none, 1 start timeout, 2 end timeout, 3 order error.
- cur_test  out  4  expected test ID.
- cur_pass  out  8  completed-pass count.
- lat_valid  out  1  one-cycle pulse on each accepted end marker.
- lat_test  out  4  test ID for lat_cycles.
- lat_cycles  out  CNT_W  start-to-end cycle count. Saturating.
- max_lat  out  CNT_W  combinational readout of the per-test maximum latency indexed by rd_idx. Returns 0 when rd_idx >= NUM_TESTS.

Behaviour:
- Reset (resetb low at a clock edge):
  - All outputs 0, state IDLE.
  - Sync flops, accepted value, counters and the max-latency array cleared.
  - Applies from any state, including mid-test.
- Input conditioning:
  - checkbits passes through a 2-flop synchronizer.
  - A stability counter accepts the synced value after STABLE_CYC consecutive identical samples.
  - Result: a raw value held constant from edge T produces an event at edge T+2+STABLE_CYC. With defaults that is T+6.
  - An event fires only when the accepted value differs from the previous accepted value. A held marker produces one event.
  - Glitches shorter than STABLE_CYC samples never produce an event.
- Marker decode: bits [CHECK_W-1:8]==MAGIC, id=[7:4], phase=[3:0]. Phase 0 is start, phase 1 is end. Events with a non-MAGIC prefix, or with any other phase value, are ignored.
- FSM:
  - IDLE: on arm go to WAIT_START. cur_test=0, cur_pass=0, timeout counter cleared.
  - WAIT_START:
    - Start event with id==cur_test: go to WAIT_END, lat counter=0.
    - Any other MAGIC event: go to FAIL, code 3.
    - Timeout counter reaches TIMEOUT: go to FAIL, code 1.
  - WAIT_END:
    - lat counter increments every cycle, saturating at all-ones.
    - End event with id==cur_test: pulse lat_valid; lat_cycles = lat counter value (cycles between the two events); update max_lat[cur_test] if larger.
    - After the end event, advance cur_test. On wrap from NUM_TESTS-1 to 0, increment cur_pass. If cur_pass reaches RERUNS, go to DONE, else go to WAIT_START.
    - Any other MAGIC event: go to FAIL, code 3.
    - Timeout: go to FAIL, code 2.
  - Timeout counter: clears on every state transition and on each accepted expected marker. Counts in WAIT_START and WAIT_END only.
  - DONE: done=1. Terminal until reset. arm ignored.
  - FAIL: fail=1, fail_code held. Terminal until reset. cur_test and cur_pass frozen for debug.
- Simultaneous events:
  - arm outside IDLE is ignored.
  - A marker event and timeout expiry in the same cycle: the marker wins.
  - lat_valid and the DONE transition occur in the same cycle.

Test Plan:
- Nominal: arm, then drive AB00/AB01/AB10/AB11/AB20/AB21 three times, each value held 20 cycles -> 9 lat_valid pulses with lat_cycles=20. Then done=1, cur_pass=3, fail=0, max_lat[0..2]=20, max_lat for rd_idx=3 reads 0.
- Latency edge: hold AB00 from edge T -> state WAIT_END observed at T+7. AB01 after 100 cycles -> lat_cycles=100.
- Glitch/deglitch: 3-cycle pulse of AB00 -> no state change. Non-MAGIC value 1234 and marker AB05 -> ignored.
- Order error: after AB00, drive AB11 -> fail=1, fail_code=3, cur_test=0. A later arm has no effect.
- Timeouts: TIMEOUT=50; arm with no marker -> fail_code=1 at 50 cycles after arm. In a separate run, AB00 then silence -> fail_code=2.
- Reset mid-test: resetb low for 1 cycle during WAIT_END of pass 2 -> all outputs 0, IDLE. A new arm restarts from test 0, pass 0.

Source files
------------

// File: rtl/checkpoint_monitor.sv
`default_nettype none
// ============================================================================
// checkpoint_monitor : deglitches the firmware checkpoint bus, sequences the
// start/end markers of each test pass, and reports latency/timeout/order errors.
// Revision : 1.0
// ============================================================================
module checkpoint_monitor #(
  parameter int         CHECK_W    = 16,
  parameter logic [7:0] MAGIC      = 8'hAB,
  parameter int         NUM_TESTS  = 3,
  parameter int         RERUNS     = 3,
  parameter int         CNT_W      = 24,
  parameter int         TIMEOUT    = 250000,
  parameter int         STABLE_CYC = 4
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic [CHECK_W-1:0] checkbits_i,
  input  logic               arm_i,
  input  logic [3:0]         rd_idx_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               fail_o,
  output logic [1:0]         fail_code_o,
  output logic [3:0]         cur_test_o,
  output logic [7:0]         cur_pass_o,
  output logic               lat_valid_o,
  output logic [3:0]         lat_test_o,
  output logic [CNT_W-1:0]   lat_cycles_o,
  output logic [CNT_W-1:0]   max_lat_o
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);

  localparam logic [2:0] C_IDLE       = 3'd0;
  localparam logic [2:0] C_WAIT_START = 3'd1;
  localparam logic [2:0] C_WAIT_END   = 3'd2;
  localparam logic [2:0] C_DONE       = 3'd3;
  localparam logic [2:0] C_FAIL       = 3'd4;

  localparam logic [1:0] C_CODE_NONE  = 2'd0;
  localparam logic [1:0] C_CODE_START = 2'd1;
  localparam logic [1:0] C_CODE_END   = 2'd2;
  localparam logic [1:0] C_CODE_ORDER = 2'd3;

  // Input conditioning
  logic [CHECK_W-1:0] sync1_q, sync2_q, cand_q, acc_q;
  logic [STAB_W-1:0]  stab_q;
  logic               w_stable, w_evt;

  assign w_stable = (stab_q == STAB_W'(STABLE_CYC));
  // A candidate that has been seen STABLE_CYC times in a row and differs from
  // the last accepted value is a new event; it is accepted on the same edge.
  assign w_evt    = w_stable && (cand_q != acc_q);

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      acc_q   <= '0;
      stab_q  <= '0;
    end else begin
      sync1_q <= checkbits_i;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        stab_q <= STAB_W'(1);
      end else if (!w_stable) begin
        stab_q <= stab_q + 1'b1;
      end
      if (w_evt) acc_q <= cand_q;
    end
  end

  // Marker decode
  logic [3:0] w_id, w_phase;
  logic       w_mevt, w_start_ok, w_end_ok;

  assign w_id       = cand_q[7:4];
  assign w_phase    = cand_q[3:0];
  assign w_mevt     = w_evt && (cand_q[CHECK_W-1:CHECK_W-8] == MAGIC) &&
                      ((w_phase == 4'd0) || (w_phase == 4'd1));
  assign w_start_ok = w_mevt && (w_phase == 4'd0) && (w_id == cur_test_q);
  assign w_end_ok   = w_mevt && (w_phase == 4'd1) && (w_id == cur_test_q);

  // Sequencer state
  logic [2:0]       state_q, state_d;
  logic [3:0]       cur_test_q, cur_test_d;
  logic [7:0]       cur_pass_q, cur_pass_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [1:0]       code_q, code_d;
  logic             lat_valid_q, lat_valid_d;
  logic [3:0]       lat_test_q, lat_test_d;
  logic [CNT_W-1:0] lat_cycles_q, lat_cycles_d;
  logic [CNT_W-1:0] max_lat_q [NUM_TESTS];
  logic [CNT_W-1:0] w_lat_inc;
  logic             w_tmo_hit, w_upd;

  assign w_lat_inc = (lat_q == '1) ? lat_q : lat_q + 1'b1;
  assign w_tmo_hit = (tmo_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state_q      <= C_IDLE;
      cur_test_q   <= '0;
      cur_pass_q   <= '0;
      tmo_q        <= '0;
      lat_q        <= '0;
      code_q       <= C_CODE_NONE;
      lat_valid_q  <= 1'b0;
      lat_test_q   <= '0;
      lat_cycles_q <= '0;
      for (int i = 0; i < NUM_TESTS; i++) max_lat_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cur_test_q   <= cur_test_d;
      cur_pass_q   <= cur_pass_d;
      tmo_q        <= tmo_d;
      lat_q        <= lat_d;
      code_q       <= code_d;
      lat_valid_q  <= lat_valid_d;
      lat_test_q   <= lat_test_d;
      lat_cycles_q <= lat_cycles_d;
      for (int i = 0; i < NUM_TESTS; i++) begin
        if (w_upd && (cur_test_q == 4'(i)) && (w_lat_inc > max_lat_q[i]))
          max_lat_q[i] <= w_lat_inc;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_test_d   = cur_test_q;
    cur_pass_d   = cur_pass_q;
    tmo_d        = tmo_q;
    lat_d        = lat_q;
    code_d       = code_q;
    lat_valid_d  = 1'b0;
    lat_test_d   = lat_test_q;
    lat_cycles_d = lat_cycles_q;
    w_upd        = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (arm_i) begin
          state_d    = C_WAIT_START;
          cur_test_d = '0;
          cur_pass_d = '0;
          tmo_d      = '0;
        end
      end
      C_WAIT_START: begin
        tmo_d = tmo_q + 1'b1;
        // Marker decisions take priority over a coincident timeout.
        if (w_start_ok) begin
          state_d = C_WAIT_END;
          lat_d   = '0;
          tmo_d   = '0;
        end else if (w_mevt) begin
          state_d = C_FAIL;
          code_d  = C_CODE_ORDER;
          tmo_d   = '0;
        end else if (w_tmo_hit) begin
          state_d = C_FAIL;
          code_d  = C_CODE_START;
          tmo_d   = '0;
        end
      end
      C_WAIT_END: begin
        tmo_d = tmo_q + 1'b1;
        lat_d = w_lat_inc;
        if (w_end_ok) begin
          lat_valid_d  = 1'b1;
          lat_cycles_d = w_lat_inc;
          lat_test_d   = cur_test_q;
          w_upd        = 1'b1;
          tmo_d        = '0;
          if (cur_test_q == 4'(NUM_TESTS - 1)) begin
            cur_test_d = '0;
            cur_pass_d = cur_pass_q + 1'b1;
            state_d    = (cur_pass_q + 1'b1 == 8'(RERUNS)) ? C_DONE : C_WAIT_START;
          end else begin
            cur_test_d = cur_test_q + 1'b1;
            state_d    = C_WAIT_START;
          end
        end else if (w_mevt) begin
          state_d = C_FAIL;
          code_d  = C_CODE_ORDER;
          tmo_d   = '0;
        end else if (w_tmo_hit) begin
          state_d = C_FAIL;
          code_d  = C_CODE_END;
          tmo_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == C_WAIT_START) || (state_q == C_WAIT_END);
    done_o       = (state_q == C_DONE);
    fail_o       = (state_q == C_FAIL);
    fail_code_o  = code_q;
    cur_test_o   = cur_test_q;
    cur_pass_o   = cur_pass_q;
    lat_valid_o  = lat_valid_q;
    lat_test_o   = lat_test_q;
    lat_cycles_o = lat_cycles_q;
    max_lat_o    = '0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      if (rd_idx_i == 4'(i)) max_lat_o = max_lat_q[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_monitor.sv
`default_nettype none
// ============================================================================
// tb_checkpoint_monitor : directed vector table plus hand-written sequences.
// Revision : 1.0
// ============================================================================
module tb_checkpoint_monitor;

  logic        clk = 1'b0;
  logic        rstn, arm;
  logic [15:0] cb;
  logic [3:0]  rd_idx;
  logic        busy, done, fail, lat_valid;
  logic [1:0]  fail_code;
  logic [3:0]  cur_test, lat_test;
  logic [7:0]  cur_pass;
  logic [23:0] lat_cycles, max_lat;

  logic        rstn2, arm2;
  logic [15:0] cb2;
  logic        busy2, done2, fail2, lat_valid2;
  logic [1:0]  fail_code2;
  logic [3:0]  cur_test2, lat_test2;
  logic [7:0]  cur_pass2;
  logic [23:0] lat_cycles2, max_lat2;

  always #5 clk = ~clk;

  checkpoint_monitor dut (
    .clock_i(clk), .resetb_i(rstn), .checkbits_i(cb), .arm_i(arm), .rd_idx_i(rd_idx),
    .busy_o(busy), .done_o(done), .fail_o(fail), .fail_code_o(fail_code),
    .cur_test_o(cur_test), .cur_pass_o(cur_pass), .lat_valid_o(lat_valid),
    .lat_test_o(lat_test), .lat_cycles_o(lat_cycles), .max_lat_o(max_lat)
  );

  checkpoint_monitor #(.TIMEOUT(50)) dut2 (
    .clock_i(clk), .resetb_i(rstn2), .checkbits_i(cb2), .arm_i(arm2), .rd_idx_i(4'd0),
    .busy_o(busy2), .done_o(done2), .fail_o(fail2), .fail_code_o(fail_code2),
    .cur_test_o(cur_test2), .cur_pass_o(cur_pass2), .lat_valid_o(lat_valid2),
    .lat_test_o(lat_test2), .lat_cycles_o(lat_cycles2), .max_lat_o(max_lat2)
  );

  typedef struct {
    logic [15:0] cb;
    int          hold;
    int          pulses;
    logic [3:0]  ct;
    logic [7:0]  cp;
    logic        dn;
    logic        bz;
    logic [23:0] lat;
  } vec_t;

  vec_t tbl[$];
  int n_checks = 0;
  int n_errors = 0;
  int pulses = 0;
  logic [23:0] last_lat = '0;
  logic [3:0]  last_id = '0;

  always @(negedge clk) begin
    if (lat_valid) begin
      pulses   <= pulses + 1;
      last_lat <= lat_cycles;
      last_id  <= lat_test;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    rd_idx = 4'd0;
    #0;
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " fail"}, 32'(fail), 0);
    chk({tag, " fail_code"}, 32'(fail_code), 0);
    chk({tag, " cur_test"}, 32'(cur_test), 0);
    chk({tag, " cur_pass"}, 32'(cur_pass), 0);
    chk({tag, " lat_valid"}, 32'(lat_valid), 0);
    chk({tag, " lat_test"}, 32'(lat_test), 0);
    chk({tag, " lat_cycles"}, 32'(lat_cycles), 0);
    chk({tag, " max_lat0"}, 32'(max_lat), 0);
  endtask

  task automatic do_reset1();
    rstn = 1'b0; cb = '0; arm = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(5);
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = tbl[i];
    cb = v.cb;
    pulses = 0;
    tick(v.hold);
    chk($sformatf("v%0d pulses", i), 32'(pulses), 32'(v.pulses));
    chk($sformatf("v%0d cur_test", i), 32'(cur_test), 32'(v.ct));
    chk($sformatf("v%0d cur_pass", i), 32'(cur_pass), 32'(v.cp));
    chk($sformatf("v%0d done", i), 32'(done), 32'(v.dn));
    chk($sformatf("v%0d busy", i), 32'(busy), 32'(v.bz));
    chk($sformatf("v%0d fail", i), 32'(fail), 0);
    if (v.pulses == 1) begin
      chk($sformatf("v%0d lat_cycles", i), 32'(last_lat), 32'(v.lat));
      chk($sformatf("v%0d lat_test", i), 32'(last_id), 32'(v.cb[7:4]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Glitch / ignored-value vectors, applied in WAIT_START of test 0.
    tbl.push_back('{16'hAB00, 3,  0, 4'd0, 8'd0, 1'b0, 1'b1, 24'd0});
    tbl.push_back('{16'h0000, 20, 0, 4'd0, 8'd0, 1'b0, 1'b1, 24'd0});
    tbl.push_back('{16'h1234, 20, 0, 4'd0, 8'd0, 1'b0, 1'b1, 24'd0});
    tbl.push_back('{16'hAB05, 20, 0, 4'd0, 8'd0, 1'b0, 1'b1, 24'd0});
    // Nominal: three passes of three tests, every marker held 20 cycles.
    for (int p = 0; p < 3; p++) begin
      for (int t = 0; t < 3; t++) begin
        logic last;
        last = (p == 2) && (t == 2);
        tbl.push_back('{16'hAB00 | 16'(t << 4), 20, 0, 4'(t), 8'(p), 1'b0, 1'b1, 24'd0});
        tbl.push_back('{16'hAB01 | 16'(t << 4), 20, 1, 4'((t + 1) % 3),
                        8'(p + ((t == 2) ? 1 : 0)), last, !last, 24'd20});
      end
    end

    rstn = 1'b0; arm = 1'b0; cb = '0; rd_idx = '0;
    rstn2 = 1'b0; arm2 = 1'b0; cb2 = '0;
    tick(3);
    check_idle("reset");
    rstn = 1'b1; rstn2 = 1'b1;
    tick(5);

    arm_pulse();
    chk("armed busy", 32'(busy), 1);
    for (int i = 0; i < tbl.size(); i++) run_vec(i);

    chk("nominal done", 32'(done), 1);
    chk("nominal cur_pass", 32'(cur_pass), 3);
    for (int r = 0; r < 4; r++) begin
      rd_idx = 4'(r);
      #1;
      chk($sformatf("max_lat[%0d]", r), 32'(max_lat), (r < 3) ? 32'd20 : 32'd0);
    end
    rd_idx = 4'd15;
    #1;
    chk("max_lat[15]", 32'(max_lat), 0);
    arm_pulse();
    tick(5);
    chk("done re-arm done", 32'(done), 1);
    chk("done re-arm busy", 32'(busy), 0);

    // Reset in the middle of WAIT_END on pass 2, then restart cleanly.
    do_reset1();
    arm_pulse();
    for (int i = 4; i < 16; i++) run_vec(i);
    cb = 16'hAB00;
    tick(10);
    chk("mid busy", 32'(busy), 1);
    chk("mid cur_pass", 32'(cur_pass), 2);
    rstn = 1'b0;
    tick(1);
    check_idle("mid reset");
    rstn = 1'b1;
    cb = '0;
    tick(10);
    arm_pulse();
    run_vec(4);
    run_vec(5);

    // Event latency: raw value from edge T reaches outputs at edge T+6.
    do_reset1();
    arm_pulse();
    tick(5);
    cb = 16'hAB00;
    tick(100);
    cb = 16'hAB01;
    tick(6);
    chk("edge lat_valid early", 32'(lat_valid), 0);
    tick(1);
    chk("edge lat_valid", 32'(lat_valid), 1);
    chk("edge lat_cycles", 32'(lat_cycles), 100);
    chk("edge lat_test", 32'(lat_test), 0);
    tick(1);
    chk("edge lat_valid single", 32'(lat_valid), 0);

    // Order error.
    do_reset1();
    arm_pulse();
    cb = 16'hAB00;
    tick(20);
    cb = 16'hAB11;
    tick(20);
    chk("order fail", 32'(fail), 1);
    chk("order code", 32'(fail_code), 3);
    chk("order cur_test", 32'(cur_test), 0);
    chk("order busy", 32'(busy), 0);
    arm_pulse();
    tick(5);
    chk("order re-arm fail", 32'(fail), 1);
    chk("order re-arm busy", 32'(busy), 0);
    chk("order re-arm code", 32'(fail_code), 3);

    // Start timeout, TIMEOUT=50.
    arm2 = 1'b1;
    tick(1);
    arm2 = 1'b0;
    chk("tmo1 busy", 32'(busy2), 1);
    tick(49);
    chk("tmo1 fail early", 32'(fail2), 0);
    tick(1);
    chk("tmo1 fail", 32'(fail2), 1);
    chk("tmo1 code", 32'(fail_code2), 1);

    // End timeout.
    rstn2 = 1'b0;
    tick(3);
    rstn2 = 1'b1;
    tick(2);
    arm2 = 1'b1;
    tick(1);
    arm2 = 1'b0;
    cb2 = 16'hAB00;
    tick(30);
    chk("tmo2 busy", 32'(busy2), 1);
    chk("tmo2 fail early", 32'(fail2), 0);
    tick(40);
    chk("tmo2 fail", 32'(fail2), 1);
    chk("tmo2 code", 32'(fail_code2), 2);
    chk("tmo2 cur_test", 32'(cur_test2), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
